// File: rtl/win_accum_pkg.sv
// Shared types and elaboration helpers for the windowed accumulator.
// The width check keeps the sum from ever wrapping inside a window.
package win_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } win_state_t;

  localparam int CNT_W = 8;

  // COUNT samples of WIDTH bits need WIDTH + clog2(COUNT) bits to never overflow.
  function automatic bit acc_width_ok(input int width, input int count, input int acc_w);
    if (count < 1 || count > 255) begin
      return 1'b0;
    end
    return acc_w >= width + $clog2(count);
  endfunction

endpackage

// File: rtl/win_accum.sv
// Sums every COUNT accepted samples (or a flushed partial window), tracks the
// window maximum, and presents each finished window on a valid/ready port.
module win_accum
  import win_accum_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int COUNT = 8,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [WIDTH-1:0]   out_max,
  output logic [CNT_W-1:0]   out_cnt
);

  if (!acc_width_ok(WIDTH, COUNT, ACC_W)) begin : g_param_bad
    $error("win_accum: COUNT out of 1..255 or ACC_W too narrow for WIDTH/COUNT");
  end

  win_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [WIDTH-1:0] out_max_q, out_max_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic             accept;
  logic             close;
  logic [ACC_W-1:0] acc_upd;
  logic [WIDTH-1:0] max_upd;
  logic [CNT_W-1:0] cnt_upd;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Post-update window values; a close snapshots these, not the old registers.
  always_comb begin
    accept  = in_valid && (state_q == ACCUM);
    acc_upd = acc_q;
    max_upd = max_q;
    cnt_upd = cnt_q;
    if (accept) begin
      acc_upd = acc_q + ACC_W'(in_data);
      max_upd = ((cnt_q == '0) || (in_data > max_q)) ? in_data : max_q;
      cnt_upd = cnt_q + 1'b1;
    end
    close = (state_q == ACCUM) &&
            ((accept && (cnt_upd == CNT_W'(COUNT))) || (flush && (cnt_upd != '0)));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (close) state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Output decode: the only non-registered output, and it depends on state alone.
  always_comb begin
    in_ready = (state_q == ACCUM);
  end

  always_comb begin
    acc_d       = acc_upd;
    max_d       = max_upd;
    cnt_d       = cnt_upd;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_max_d   = out_max_q;
    out_cnt_d   = out_cnt_q;
    if (close) begin
      out_valid_d = 1'b1;
      out_sum_d   = acc_upd;
      out_max_d   = max_upd;
      out_cnt_d   = cnt_upd;
      acc_d       = '0;
      max_d       = '0;
      cnt_d       = '0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      max_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_max_q   <= '0;
      out_cnt_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_max_q   <= out_max_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_max   = out_max_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_win_accum.sv
// Scoreboard bench for win_accum with COUNT=4: a behavioural window model
// pushes expected results, and each output handshake pops and compares one.
module tb_win_accum;

  localparam int WIDTH = 32;
  localparam int COUNT = 4;
  localparam int ACC_W = 40;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [WIDTH-1:0] max;
    logic [7:0]       cnt;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [WIDTH-1:0] out_max;
  logic [7:0]       out_cnt;

  int total = 0;
  int bad = 0;
  int stall_cnt = 0;
  int results_seen = 0;

  res_t             sb[$];
  logic [ACC_W-1:0] m_acc;
  logic [WIDTH-1:0] m_max;
  int               m_cnt;
  bit               m_hold;

  win_accum #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_max(out_max), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_acc  = '0;
    m_max  = '0;
    m_cnt  = 0;
    m_hold = 1'b0;
    sb.delete();
  endtask

  // One clock: drive inputs, check outputs against the model, advance model, step.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit f, input bit r);
    res_t e;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    total++;
    if (in_ready !== !m_hold) begin
      bad++;
      $display("FAIL in_ready: got %b want %b", in_ready, !m_hold);
    end
    total++;
    if (out_valid !== m_hold) begin
      bad++;
      $display("FAIL out_valid: got %b want %b", out_valid, m_hold);
    end
    if (in_ready === 1'b0) stall_cnt++;
    if (m_hold) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard: result present but none expected");
      end else begin
        e = sb[0];
        total++;
        if (out_sum !== e.sum) begin
          bad++;
          $display("FAIL out_sum: got %h want %h", out_sum, e.sum);
        end
        total++;
        if (out_max !== e.max) begin
          bad++;
          $display("FAIL out_max: got %h want %h", out_max, e.max);
        end
        total++;
        if (out_cnt !== e.cnt) begin
          bad++;
          $display("FAIL out_cnt: got %0d want %0d", out_cnt, e.cnt);
        end
        if (r) begin
          $display("result sum=%h max=%h cnt=%0d", out_sum, out_max, out_cnt);
          void'(sb.pop_front());
          results_seen++;
          m_hold = 1'b0;
        end
      end
    end else begin
      if (v) begin
        if (m_cnt == 0 || d > m_max) m_max = d;
        m_acc = m_acc + {8'h00, d};
        m_cnt++;
      end
      if ((v && m_cnt == COUNT) || (f && m_cnt > 0)) begin
        e.sum = m_acc;
        e.max = m_max;
        e.cnt = 8'(m_cnt);
        sb.push_back(e);
        m_hold = 1'b1;
        m_acc  = '0;
        m_max  = '0;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    total++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_max !== '0 || out_cnt !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b s=%h m=%h c=%0d want all 0",
               out_valid, out_sum, out_max, out_cnt);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && (m_hold || sb.size() != 0); i++) cycle(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results never appeared", sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_basic();
    int base;
    base = results_seen;
    stall_cnt = 0;
    cycle(1'b1, 32'd5, 1'b0, 1'b1);
    cycle(1'b1, 32'd6, 1'b0, 1'b1);
    cycle(1'b1, 32'd7, 1'b0, 1'b1);
    cycle(1'b1, 32'd8, 1'b0, 1'b1);
    drain();
    cycle(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (stall_cnt != 1) begin
      bad++;
      $display("FAIL basic_stall: got %0d stall cycles want 1", stall_cnt);
    end
    total++;
    if (results_seen - base != 1) begin
      bad++;
      $display("FAIL basic_count: got %0d results want 1", results_seen - base);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    // Offered samples during HOLD must be refused; field checks run every cycle.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'd99, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_flush();
    int base;
    cycle(1'b1, 32'd10, 1'b0, 1'b1);
    cycle(1'b1, 32'd20, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    drain();
    cycle(1'b1, 32'd10, 1'b0, 1'b1);
    cycle(1'b1, 32'd20, 1'b0, 1'b1);
    cycle(1'b1, 32'd30, 1'b1, 1'b1);
    drain();
    base = results_seen;
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (results_seen != base) begin
      bad++;
      $display("FAIL flush_empty: got %0d results want 0", results_seen - base);
    end
  endtask

  task automatic test_width_boundary();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    total++;
    if (sb.size() != 1 || sb[0].sum !== 40'h03_FFFF_FFFC) begin
      bad++;
      $display("FAIL width_model: model queue size %0d", sb.size());
    end
    drain();
  endtask

  task automatic test_mid_reset();
    int base;
    cycle(1'b1, 32'd9, 1'b0, 1'b1);
    cycle(1'b1, 32'd9, 1'b0, 1'b1);
    do_reset(1);
    base = results_seen;
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'd1, 1'b0, 1'b1);
    drain();
    total++;
    if (results_seen - base != 1) begin
      bad++;
      $display("FAIL mid_reset_count: got %0d results want 1", results_seen - base);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) cycle(1'b1, $urandom_range(0, 1000), 1'b0, 1'b1);
    drain();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_width_boundary();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
